// File: rtl/conv2d_stream_param.sv
// conv2d_stream_param: streaming KxK signed-coefficient 2-D convolution over a
// row-major image in external synchronous RAM, "same"-size output written back
// one pixel per P = K*K+2 cycles. Border handling is zero (PAD_MODE=0) or
// replicate (PAD_MODE=1); the accumulator is arithmetically shifted by SHIFT.
// Optional feature macro CONV2D_SAT_EN: when defined the scaled result is
// saturated to the signed OUT_W range, otherwise it wraps to its low OUT_W bits.
module conv2d_stream_param #(
    parameter int IMG_W    = 50,
    parameter int IMG_H    = 50,
    parameter int K        = 5,
    parameter int DATA_W   = 12,
    parameter int COEF_W   = 8,
    parameter int OUT_W    = 20,
    parameter int ADDR_W   = 17,
    parameter int SHIFT    = 0,
    parameter int PAD_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [K*K*COEF_W-1:0]      f_coeff,
    input  logic [DATA_W-1:0]          d_in,
    output logic [ADDR_W-1:0]          ReadAddress,
    output logic [ADDR_W-1:0]          WriteAddress,
    output logic signed [OUT_W-1:0]    d_out,
    output logic                       WriteEnable,
    output logic                       ready,
    output logic                       done
);

    localparam int NTAP   = K * K;
    localparam int HALF   = K / 2;
    localparam int P      = NTAP + 2;
    localparam int PH_W   = $clog2(P);
    localparam int TAP_W  = $clog2(NTAP);
    localparam int ROW_W  = $clog2(IMG_H + 1);
    localparam int COL_W  = $clog2(IMG_W + 1);
    localparam int KR_W   = $clog2(K + 1);
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(NTAP) + 1;

    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(P - 1);
    localparam logic [PH_W-1:0]  PH_TAP0   = PH_W'(2);
    localparam logic [PH_W-1:0]  PH_NTAP   = PH_W'(NTAP);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [KR_W-1:0]  KC_LAST   = KR_W'(K - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Reduce the scaled accumulator to OUT_W bits (saturate or wrap).
    function automatic logic signed [OUT_W-1:0] reduce_fn(input logic signed [ACC_W-1:0] v);
`ifdef CONV2D_SAT_EN
        localparam int WIDE_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
        localparam logic signed [WIDE_W-1:0] MAX_V = {{(WIDE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        localparam logic signed [WIDE_W-1:0] MIN_V = ~MAX_V;
        logic signed [WIDE_W-1:0] w;
        w = WIDE_W'(v);
        if (w > MAX_V) begin
            reduce_fn = OUT_W'(MAX_V);
        end else if (w < MIN_V) begin
            reduce_fn = OUT_W'(MIN_V);
        end else begin
            reduce_fn = OUT_W'(w);
        end
`else
        reduce_fn = OUT_W'(v);
`endif
    endfunction

    state_t                    state_r, state_s;
    logic signed [COEF_W-1:0]  coef_r [NTAP];
    logic [ROW_W-1:0]          row_r;
    logic [COL_W-1:0]          col_r;
    logic [KR_W-1:0]           kr_r, kc_r;
    logic [PH_W-1:0]           ph_r;
    logic                      mask_d1_r, mask_d2_r;
    logic signed [ACC_W-1:0]   acc_r;

    logic                      accept_s, issue_s, acc_en_s, tap_vld_s, wr_s, fin_s;
    int                        src_row_s, src_col_s, clamp_row_s, clamp_col_s;
    logic                      in_rng_s, mask_s;
    logic [ADDR_W-1:0]         rd_addr_s, wr_addr_s;
    logic [TAP_W-1:0]          tap_s;
    logic signed [COEF_W-1:0]  coef_sel_s;
    logic signed [DATA_W:0]    pix_s;
    logic signed [PROD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]   acc_next_s, scaled_s;
    logic signed [OUT_W-1:0]   result_s;

    // Next-state and per-cycle control strobes derived from the pixel phase.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        issue_s   = 1'b0;
        acc_en_s  = 1'b0;
        tap_vld_s = 1'b0;
        wr_s      = 1'b0;
        fin_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = ST_MAC;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (ph_r < PH_NTAP) begin
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
                if ((ph_r >= PH_TAP0) && (ph_r <= PH_LAST)) begin
                    tap_vld_s = 1'b1;
                end else begin
                    tap_vld_s = 1'b0;
                end
                if ((ph_r >= PH_TAP0) && (ph_r <= PH_NTAP)) begin
                    acc_en_s = 1'b1;
                end else begin
                    acc_en_s = 1'b0;
                end
                if (ph_r == PH_LAST) begin
                    wr_s = 1'b1;
                    if ((row_r == ROW_LAST) && (col_r == COL_LAST)) begin
                        state_s = ST_FIN;
                    end else begin
                        state_s = ST_MAC;
                    end
                end else begin
                    state_s = ST_MAC;
                end
            end
            ST_FIN: begin
                fin_s   = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Source coordinate of the tap being issued, clamped address and border mask.
    always_comb begin
        src_row_s = int'(row_r) + int'(kr_r) - HALF;
        src_col_s = int'(col_r) + int'(kc_r) - HALF;
        in_rng_s  = (src_row_s >= 0) && (src_row_s < IMG_H) &&
                    (src_col_s >= 0) && (src_col_s < IMG_W);
        if (src_row_s < 0) begin
            clamp_row_s = 0;
        end else if (src_row_s > IMG_H - 1) begin
            clamp_row_s = IMG_H - 1;
        end else begin
            clamp_row_s = src_row_s;
        end
        if (src_col_s < 0) begin
            clamp_col_s = 0;
        end else if (src_col_s > IMG_W - 1) begin
            clamp_col_s = IMG_W - 1;
        end else begin
            clamp_col_s = src_col_s;
        end
        mask_s    = (PAD_MODE == 1) ? 1'b1 : in_rng_s;
        rd_addr_s = ADDR_W'(clamp_row_s * IMG_W + clamp_col_s);
        wr_addr_s = ADDR_W'(int'(row_r) * IMG_W + int'(col_r));
    end

    // Multiply the returning pixel by its tap coefficient and form the result.
    always_comb begin
        tap_s      = TAP_W'(ph_r - PH_TAP0);
        if (tap_vld_s) begin
            coef_sel_s = coef_r[tap_s];
        end else begin
            coef_sel_s = '0;
        end
        if (mask_d2_r) begin
            pix_s = $signed({1'b0, d_in});
        end else begin
            pix_s = '0;
        end
        prod_s     = PROD_W'(pix_s) * PROD_W'(coef_sel_s);
        acc_next_s = acc_r + ACC_W'(prod_s);
        scaled_s   = acc_next_s >>> SHIFT;
        result_s   = reduce_fn(scaled_s);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: coefficient latch, counters, read address, accumulator, write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int t = 0; t < NTAP; t++) begin
                coef_r[t] <= '0;
            end
            row_r        <= '0;
            col_r        <= '0;
            kr_r         <= '0;
            kc_r         <= '0;
            ph_r         <= '0;
            mask_d1_r    <= 1'b0;
            mask_d2_r    <= 1'b0;
            acc_r        <= '0;
            ReadAddress  <= '0;
            WriteAddress <= '0;
            d_out        <= '0;
            WriteEnable  <= 1'b0;
            ready        <= 1'b1;
            done         <= 1'b0;
        end else begin
            WriteEnable <= 1'b0;
            done        <= 1'b0;
            mask_d1_r   <= mask_s;
            mask_d2_r   <= mask_d1_r;
            if (accept_s) begin
                for (int t = 0; t < NTAP; t++) begin
                    coef_r[t] <= $signed(f_coeff[t*COEF_W +: COEF_W]);
                end
                row_r <= '0;
                col_r <= '0;
                kr_r  <= '0;
                kc_r  <= '0;
                ph_r  <= '0;
                acc_r <= '0;
                ready <= 1'b0;
            end
            if (state_r == ST_MAC) begin
                ph_r <= (ph_r == PH_LAST) ? '0 : ph_r + PH_W'(1);
            end
            if (issue_s) begin
                ReadAddress <= rd_addr_s;
                if (kc_r == KC_LAST) begin
                    kc_r <= '0;
                    kr_r <= kr_r + KR_W'(1);
                end else begin
                    kc_r <= kc_r + KR_W'(1);
                end
            end
            if (acc_en_s) begin
                acc_r <= acc_next_s;
            end
            if (wr_s) begin
                WriteEnable  <= 1'b1;
                WriteAddress <= wr_addr_s;
                d_out        <= result_s;
                acc_r        <= '0;
                kr_r         <= '0;
                kc_r         <= '0;
                if (col_r == COL_LAST) begin
                    col_r <= '0;
                    row_r <= row_r + ROW_W'(1);
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
            end
            if (fin_s) begin
                done  <= 1'b1;
                ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv2d_stream_param.sv
// Scoreboard bench for conv2d_stream_param: two 8x6, K=3 instances
// (A: zero padding, SHIFT=0; B: replicate, SHIFT=3), OUT_W=16.
module tb_conv2d_stream_param;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int NPIX = W * H;
    localparam int CW = 72;
`ifdef CONV2D_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start_a, start_b;
    logic [CW-1:0] coef_a, coef_b;
    logic [11:0]   d_in_a = 12'd0, d_in_b = 12'd0;
    logic [16:0]   ra_a, wa_a, ra_b, wa_b;
    logic [15:0]   dout_a, dout_b;
    logic          we_a, we_b, rdy_a, rdy_b, done_a, done_b;
    logic [11:0]   mem [0:63];

    conv2d_stream_param #(.IMG_W(W), .IMG_H(H), .K(3), .DATA_W(12), .COEF_W(8),
        .OUT_W(16), .ADDR_W(17), .SHIFT(0), .PAD_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .f_coeff(coef_a), .d_in(d_in_a),
        .ReadAddress(ra_a), .WriteAddress(wa_a), .d_out(dout_a),
        .WriteEnable(we_a), .ready(rdy_a), .done(done_a));

    conv2d_stream_param #(.IMG_W(W), .IMG_H(H), .K(3), .DATA_W(12), .COEF_W(8),
        .OUT_W(16), .ADDR_W(17), .SHIFT(3), .PAD_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .f_coeff(coef_b), .d_in(d_in_b),
        .ReadAddress(ra_b), .WriteAddress(wa_b), .d_out(dout_b),
        .WriteEnable(we_b), .ready(rdy_b), .done(done_b));

    // Synchronous image RAM model, one read port per instance.
    always @(posedge clk) begin
        d_in_a <= mem[ra_a[5:0]];
        d_in_b <= mem[ra_b[5:0]];
    end

    // Cycle counter relative to the edge that accepted start on instance A.
    int cyc_a = 0;
    always @(posedge clk) begin
        cyc_a <= (start_a && rdy_a) ? 0 : cyc_a + 1;
    end

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int checks = 0;
    int errors = 0;
    int wr_cnt_a = 0, wr_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;
    int last_we_cyc_a = 0, done_cyc_a = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // kind: 0 identity, 1 all ones, 2 all -128, 3 center -1, 4 all twos
    function automatic logic [CW-1:0] make_coef(input int kind);
        logic [CW-1:0] v;
        v = '0;
        for (int t = 0; t < 9; t++) begin
            case (kind)
                1: v[t*8 +: 8] = 8'd1;
                2: v[t*8 +: 8] = 8'h80;
                4: v[t*8 +: 8] = 8'd2;
                default: ;
            endcase
        end
        if (kind == 0) v[32 +: 8] = 8'd1;
        if (kind == 3) v[32 +: 8] = 8'hFF;
        return v;
    endfunction

    // Hand-derived expected output per pixel.
    function automatic int expect_px(input int dut, input int kind, input int r, input int c);
        int n;
        int i;
        i = r * W + c;
        n = ((r == 0 || r == H - 1) ? 2 : 3) * ((c == 0 || c == W - 1) ? 2 : 3);
        if (dut == 0) begin
            case (kind)
                0: return i;                          // identity
                1: return 100 * n;                    // 900 / 600 / 400
                2: return SAT ? -32768 : 128 * n;     // -n*524160 mod 2^16 = 128n
                default: return 0;
            endcase
        end else begin
            case (kind)
                1: return 112;                        // 900 >>> 3
                2: return SAT ? -32768 : 144;         // -589680 mod 2^16
                3: return -((i + 7) / 8);             // floor(-i/8)
                default: return 0;
            endcase
        end
    endfunction

    task automatic load(input int dut, input int kind);
        exp_t e;
        for (int i = 0; i < 64; i++) begin
            mem[i] = (kind == 0 || kind == 3) ? 12'(i) : ((kind == 1) ? 12'd100 : 12'd4095);
        end
        if (dut == 0) coef_a = make_coef(kind);
        else          coef_b = make_coef(kind);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                e.addr = r * W + c;
                e.data = expect_px(dut, kind, r, c);
                if (dut == 0) q_a.push_back(e);
                else          q_b.push_back(e);
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (we_a) begin
                wr_cnt_a++;
                last_we_cyc_a = cyc_a;
                if (q_a.size() == 0) begin
                    check("unexpected_write_a", int'(wa_a), -1);
                end else begin
                    e = q_a.pop_front();
                    check("addr_a", int'(wa_a), e.addr);
                    check("data_a", int'($signed(dout_a)), e.data);
                end
            end
            if (we_b) begin
                wr_cnt_b++;
                if (q_b.size() == 0) begin
                    check("unexpected_write_b", int'(wa_b), -1);
                end else begin
                    e = q_b.pop_front();
                    check("addr_b", int'(wa_b), e.addr);
                    check("data_b", int'($signed(dout_b)), e.data);
                end
            end
            if (done_a) begin
                done_cnt_a++;
                done_cyc_a = cyc_a;
            end
            if (done_b) done_cnt_b++;
        end
    endtask

    task automatic start_frame(input int dut);
        int n = 0;
        while (((dut == 0) ? !rdy_a : !rdy_b) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_start", int'(n < 100), 1);
        if (dut == 0) start_a = 1'b1;
        else          start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic run_frame(input int dut, input int kind, input bit disturb);
        int w0, d0, n;
        load(dut, kind);
        w0 = (dut == 0) ? wr_cnt_a : wr_cnt_b;
        d0 = (dut == 0) ? done_cnt_a : done_cnt_b;
        start_frame(dut);
        if (disturb) begin
            repeat (50) @(negedge clk);
            coef_a  = make_coef(4);
            start_a = 1'b1;
            repeat (3) @(negedge clk);
            start_a = 1'b0;
        end
        n = 0;
        while (((dut == 0) ? done_cnt_a : done_cnt_b) == d0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", int'(n < 2000), 1);
        repeat (3) @(negedge clk);
        check("write_count", ((dut == 0) ? wr_cnt_a : wr_cnt_b) - w0, NPIX);
        check("done_pulses", ((dut == 0) ? done_cnt_a : done_cnt_b) - d0, 1);
        check("queue_drained", (dut == 0) ? q_a.size() : q_b.size(), 0);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_we"},    int'(we_a), 0);
        check({tag, "_ready"}, int'(rdy_a), 1);
        check({tag, "_done"},  int'(done_a), 0);
        check({tag, "_raddr"}, int'(ra_a), 0);
        check({tag, "_waddr"}, int'(wa_a), 0);
        check({tag, "_dout"},  int'(dout_a), 0);
    endtask

    initial begin
        int w0, d0, n;
        rst     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        coef_a  = '0;
        coef_b  = '0;
        for (int i = 0; i < 64; i++) mem[i] = 12'd0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check_reset_a("reset");
        check("reset_ready_b", int'(rdy_b), 1);
        rst = 1'b1;
        @(negedge clk);

        // Identity frame with latency checks
        run_frame(0, 0, 1'b0);
        check("last_we_cycle", last_we_cyc_a, 528);
        check("done_cycle", done_cyc_a, 529);

        // Zero-padded all-ones, saturating/wrapping -128 kernel
        run_frame(0, 1, 1'b0);
        run_frame(0, 2, 1'b0);

        // Mid-frame start and coefficient change must be ignored
        run_frame(0, 1, 1'b1);

        // Replicate + shift instance
        run_frame(1, 1, 1'b0);
        run_frame(1, 3, 1'b0);
        run_frame(1, 2, 1'b0);

        // Reset during pixel 10, then a fresh frame
        load(0, 0);
        w0 = wr_cnt_a;
        d0 = done_cnt_a;
        start_frame(0);
        n = 0;
        while (cyc_a != 115 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("reach_pixel10", int'(n < 300), 1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_a("abort");
        q_a.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_writes", wr_cnt_a - w0, 10);
        check("abort_no_done", done_cnt_a - d0, 0);
        run_frame(0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
